// File: rtl/dev_reshuffler_csr_pkg.sv
// Shared types and address/bit constants for the reshuffler CSR manager.
// Addresses are offsets from NumRwCsr so the map follows the RW register count.
package dev_reshuffler_csr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } csr_mgr_state_e;

  localparam int unsigned START_BIT  = 0;
  localparam int unsigned BUSY_BIT   = 0;
  localparam int unsigned LAUNCH_BIT = 1;

  localparam int unsigned CTRL_OFS     = 0;
  localparam int unsigned PERF_CYC_OFS = 1;
  localparam int unsigned PERF_OPS_OFS = 2;

endpackage

// File: rtl/dev_csr_perf_counter.sv
// Wrapping performance counter; a clear in the same cycle as an increment wins.
module dev_csr_perf_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else if (inc_i) begin
      count_o <= count_o + Width'(1);
    end
  end

endmodule

// File: rtl/dev_reshuffler_csr_mgr.sv
// CSR manager: RW config registers, CTRL start/launch handshake, perf counters.
// state  | meaning
// IDLE   | no operation; config writable, CTRL start accepted
// LAUNCH | cfg_o snapshot presented with cfg_valid_o, waiting for cfg_ready_i
// BUSY   | accelerator running, waiting for acc_done_i
module dev_reshuffler_csr_mgr
  import dev_reshuffler_csr_pkg::*;
#(
  parameter  int unsigned NumRwCsr     = 4,
  parameter  int unsigned RegDataWidth = 32,
  localparam int unsigned NumCsr       = NumRwCsr + 3,
  localparam int unsigned RegAddrWidth = $clog2(NumCsr)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [RegAddrWidth-1:0]          csr_addr_i,
  input  logic [RegDataWidth-1:0]          csr_wr_data_i,
  input  logic                             csr_wr_en_i,
  input  logic                             csr_req_valid_i,
  output logic                             csr_req_ready_o,
  output logic [RegDataWidth-1:0]          csr_rd_data_o,
  output logic                             csr_rsp_valid_o,
  input  logic                             csr_rsp_ready_i,
  output logic [NumRwCsr*RegDataWidth-1:0] cfg_o,
  output logic                             cfg_valid_o,
  input  logic                             cfg_ready_i,
  input  logic                             acc_done_i,
  output logic                             busy_o
);

  localparam int unsigned CtrlIdx    = NumRwCsr + CTRL_OFS;
  localparam int unsigned PerfCycIdx = NumRwCsr + PERF_CYC_OFS;
  localparam int unsigned PerfOpsIdx = NumRwCsr + PERF_OPS_OFS;

  csr_mgr_state_e                    state_q, state_d;
  logic [NumRwCsr*RegDataWidth-1:0]  cfg_q;
  logic [RegDataWidth-1:0]           rd_val;
  logic [RegDataWidth-1:0]           perf_cyc, perf_ops;
  logic [31:0]                       addr_ext;
  logic                              lock, accept, wr_acc, start;

  assign addr_ext = 32'(csr_addr_i);

  // Only config/CTRL writes stall while an operation is in flight.
  assign lock            = (state_q != IDLE) && csr_wr_en_i && (addr_ext <= CtrlIdx);
  assign csr_req_ready_o = (!csr_rsp_valid_o || csr_rsp_ready_i) && !lock;
  assign accept          = csr_req_valid_i && csr_req_ready_o;
  assign wr_acc          = accept && csr_wr_en_i;
  assign start           = wr_acc && (addr_ext == CtrlIdx) && csr_wr_data_i[START_BIT];

  assign busy_o      = (state_q != IDLE);
  assign cfg_valid_o = (state_q == LAUNCH);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NumRwCsr; i++) begin
      if (addr_ext == 32'(i)) rd_val = cfg_q[i*RegDataWidth +: RegDataWidth];
    end
    if (addr_ext == CtrlIdx) begin
      rd_val[BUSY_BIT]   = busy_o;
      rd_val[LAUNCH_BIT] = (state_q == LAUNCH);
    end
    if (addr_ext == PerfCycIdx) rd_val = perf_cyc;
    if (addr_ext == PerfOpsIdx) rd_val = perf_ops;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NumRwCsr; i++) begin
        if (addr_ext == 32'(i)) cfg_q[i*RegDataWidth +: RegDataWidth] <= csr_wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_o <= '0;
    end else if (start) begin
      cfg_o <= cfg_q;
    end
  end

  // Response register carries read-before-write data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csr_rsp_valid_o <= 1'b0;
      csr_rd_data_o   <= '0;
    end else if (accept) begin
      csr_rsp_valid_o <= 1'b1;
      csr_rd_data_o   <= rd_val;
    end else if (csr_rsp_valid_o && csr_rsp_ready_i) begin
      csr_rsp_valid_o <= 1'b0;
      csr_rd_data_o   <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)       state_d = LAUNCH;
      LAUNCH:  if (cfg_ready_i) state_d = BUSY;
      BUSY:    if (acc_done_i)  state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  dev_csr_perf_counter #(.Width(RegDataWidth)) u_perf_cyc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (busy_o),
    .clr_i   (wr_acc && (addr_ext == PerfCycIdx)),
    .count_o (perf_cyc)
  );

  dev_csr_perf_counter #(.Width(RegDataWidth)) u_perf_ops (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   ((state_q == BUSY) && acc_done_i),
    .clr_i   (wr_acc && (addr_ext == PerfOpsIdx)),
    .count_o (perf_ops)
  );

endmodule

// File: tb/tb_dev_reshuffler_csr_mgr.sv
// Bench for dev_reshuffler_csr_mgr: reference model feeds an expected-response
// queue; a negedge monitor compares responses and per-cycle status outputs.
module tb_dev_reshuffler_csr_mgr;

  localparam int NRW = 4;
  localparam int W   = 32;
  localparam int AW  = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [AW-1:0]     csr_addr_i;
  logic [W-1:0]      csr_wr_data_i;
  logic              csr_wr_en_i;
  logic              csr_req_valid_i;
  logic              csr_req_ready_o;
  logic [W-1:0]      csr_rd_data_o;
  logic              csr_rsp_valid_o;
  logic              csr_rsp_ready_i;
  logic [NRW*W-1:0]  cfg_o;
  logic              cfg_valid_o;
  logic              cfg_ready_i;
  logic              acc_done_i;
  logic              busy_o;

  dev_reshuffler_csr_mgr #(.NumRwCsr(NRW), .RegDataWidth(W)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .csr_addr_i      (csr_addr_i),
    .csr_wr_data_i   (csr_wr_data_i),
    .csr_wr_en_i     (csr_wr_en_i),
    .csr_req_valid_i (csr_req_valid_i),
    .csr_req_ready_o (csr_req_ready_o),
    .csr_rd_data_o   (csr_rd_data_o),
    .csr_rsp_valid_o (csr_rsp_valid_o),
    .csr_rsp_ready_i (csr_rsp_ready_i),
    .cfg_o           (cfg_o),
    .cfg_valid_o     (cfg_valid_o),
    .cfg_ready_i     (cfg_ready_i),
    .acc_done_i      (acc_done_i),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = idle, 1 = launch presented, 2 = accelerator running.
  logic [W-1:0]     m_reg [NRW];
  int               m_phase;
  logic [W-1:0]     m_cyc, m_ops;
  logic             m_rsp_valid;
  logic [NRW*W-1:0] m_cfg;
  logic [W-1:0]     exp_q [$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_read(input int a);
    logic [W-1:0] v;
    v = '0;
    if (a < NRW) v = m_reg[a];
    else if (a == NRW) begin
      v[0] = (m_phase != 0);
      v[1] = (m_phase == 1);
    end
    else if (a == NRW + 1) v = m_cyc;
    else if (a == NRW + 2) v = m_ops;
    return v;
  endfunction

  function automatic logic model_ready();
    logic locked;
    locked = (m_phase != 0) && csr_wr_en_i && (int'(csr_addr_i) <= NRW);
    return (!m_rsp_valid || csr_rsp_ready_i) && !locked;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin : model
    logic acc;
    int   a;
    logic [W-1:0] nc, no;
    if (!rst_ni) begin
      for (int i = 0; i < NRW; i++) m_reg[i] = '0;
      m_phase = 0; m_cyc = '0; m_ops = '0; m_rsp_valid = 1'b0; m_cfg = '0;
      exp_q.delete();
    end else begin
      a   = int'(csr_addr_i);
      acc = csr_req_valid_i && model_ready();
      nc  = (m_phase != 0) ? m_cyc + 1 : m_cyc;
      no  = (m_phase == 2 && acc_done_i) ? m_ops + 1 : m_ops;
      if (acc) begin
        exp_q.push_back(model_read(a));
        m_rsp_valid = 1'b1;
      end else if (m_rsp_valid && csr_rsp_ready_i) begin
        m_rsp_valid = 1'b0;
      end
      case (m_phase)
        0: if (acc && csr_wr_en_i && a == NRW && csr_wr_data_i[0]) begin
             for (int i = 0; i < NRW; i++) m_cfg[i*W +: W] = m_reg[i];
             m_phase = 1;
           end
        1: if (cfg_ready_i) m_phase = 2;
        default: if (acc_done_i) m_phase = 0;
      endcase
      if (acc && csr_wr_en_i) begin
        if (a < NRW) m_reg[a] = csr_wr_data_i;
        if (a == NRW + 1) nc = '0;
        if (a == NRW + 2) no = '0;
      end
      m_cyc = nc;
      m_ops = no;
    end
  end

  always @(negedge clk_i) begin : monitor
    check("req_ready", csr_req_ready_o, model_ready());
    check("rsp_valid", csr_rsp_valid_o, m_rsp_valid);
    check("busy", busy_o, m_phase != 0);
    check("cfg_valid", cfg_valid_o, m_phase == 1);
    check("cfg_o", cfg_o, m_cfg);
    if (csr_rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        check("rsp_data", csr_rd_data_o, exp_q[0]);
        if (csr_rsp_ready_i) void'(exp_q.pop_front());
      end
    end else begin
      check("rsp_idle_data", csr_rd_data_o, '0);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input int a, input logic wr, input logic [W-1:0] d);
    int n;
    csr_addr_i = AW'(a); csr_wr_en_i = wr; csr_wr_data_i = d; csr_req_valid_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (csr_req_ready_o) break;
      n++;
      if (n > 200) begin
        check("req_timeout", 1'b1, 1'b0);
        break;
      end
    end
    cyc();
    csr_req_valid_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; csr_addr_i = '0; csr_wr_data_i = '0; csr_wr_en_i = 1'b0;
    csr_req_valid_i = 1'b0; csr_rsp_ready_i = 1'b1; cfg_ready_i = 1'b0; acc_done_i = 1'b0;
    repeat (3) cyc();
    rst_ni = 1'b1;
    cyc();

    // Basic write then read-back.
    req(0, 1'b1, 32'hA5);
    req(0, 1'b0, 0);
    cyc();

    // Launch with the accelerator holding off, then accept.
    req(0, 1'b1, 32'h11); req(1, 1'b1, 32'h22); req(2, 1'b1, 32'h33); req(3, 1'b1, 32'h44);
    req(NRW, 1'b1, 1);
    repeat (3) cyc();
    req(NRW, 1'b0, 0);
    cfg_ready_i = 1'b1; cyc(); cfg_ready_i = 1'b0;
    req(NRW, 1'b0, 0);

    // Config writes stall while busy; reads go through.
    req(0, 1'b0, 0);
    fork
      begin
        repeat (6) cyc();
        acc_done_i = 1'b1; cyc(); acc_done_i = 1'b0;
      end
    join_none
    req(0, 1'b1, 32'h55);
    cyc();

    // Perf counters over a known-length operation.
    req(NRW + 1, 1'b1, 0); req(NRW + 2, 1'b1, 0);
    cfg_ready_i = 1'b1;
    req(NRW, 1'b1, 1);
    cyc();
    cfg_ready_i = 1'b0;
    repeat (5) cyc();
    acc_done_i = 1'b1; cyc(); acc_done_i = 1'b0;
    req(NRW + 1, 1'b0, 0); req(NRW + 2, 1'b0, 0);
    cfg_ready_i = 1'b1;
    req(NRW, 1'b1, 1);
    cyc(); cfg_ready_i = 1'b0;
    req(NRW + 1, 1'b1, 0);
    req(NRW + 1, 1'b0, 0);
    acc_done_i = 1'b1; cyc(); acc_done_i = 1'b0;

    // Response backpressure, then back-to-back responses.
    csr_rsp_ready_i = 1'b0;
    req(1, 1'b0, 0);
    csr_addr_i = AW'(2); csr_wr_en_i = 1'b0; csr_req_valid_i = 1'b1;
    repeat (3) cyc();
    csr_rsp_ready_i = 1'b1;
    cyc();
    csr_addr_i = AW'(3);
    cyc();
    csr_req_valid_i = 1'b0;
    cyc();

    // Reset during an operation, then out-of-range access.
    cfg_ready_i = 1'b1;
    req(NRW, 1'b1, 1);
    repeat (2) cyc();
    cfg_ready_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) cyc();
    rst_ni = 1'b1;
    cyc();
    req(7, 1'b0, 0);
    req(7, 1'b1, 32'hDEAD_BEEF);
    req(0, 1'b0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      csr_req_valid_i = 1'($urandom_range(0, 1));
      csr_addr_i      = AW'($urandom_range(0, 7));
      csr_wr_en_i     = ($urandom_range(0, 2) == 0);
      csr_wr_data_i   = $urandom;
      csr_rsp_ready_i = ($urandom_range(0, 3) != 0);
      cfg_ready_i     = ($urandom_range(0, 2) == 0);
      acc_done_i      = ($urandom_range(0, 7) == 0);
      cyc();
    end
    csr_req_valid_i = 1'b0; csr_rsp_ready_i = 1'b1; cfg_ready_i = 1'b0; acc_done_i = 1'b0;
    repeat (4) cyc();
    check("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
